key_debounce_capture: RTL and testbench

Multi-channel debouncer with sticky edge capture for the board push-buttons and slide switches.
- Sits between the raw `key`/`sw` pins and the Nios parallel-input ports.
- Gives the CPU clean levels, single-cycle press/release ticks, a software-clearable press-capture register and an interrupt line.
- Typically instantiated once for `key` (N=4, ACTIVE_LOW=1) and once for `sw` (N=10, ACTIVE_LOW=0).

---
 rtl/key_debounce_capture_if.sv | 25 ++
 rtl/key_debounce_capture.sv | 140 ++++++++++++++
 tb/tb_key_debounce_capture.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_capture_if.sv
// Bundle of the debouncer's pin-side inputs and CPU-side outputs.
// The master drives the raw pins and clear/mask controls; the slave is the debouncer.
interface key_debounce_capture_if #(
    parameter int N = 4
);
    logic [N-1:0] din;
    logic         clr_en;
    logic [N-1:0] clr_mask;
    logic [N-1:0] irq_mask;
    logic [N-1:0] db_level;
    logic [N-1:0] press_tick;
    logic [N-1:0] rel_tick;
    logic [N-1:0] edge_cap;
    logic         irq;

    modport master (
        output din, clr_en, clr_mask, irq_mask,
        input  db_level, press_tick, rel_tick, edge_cap, irq
    );

    modport slave (
        input  din, clr_en, clr_mask, irq_mask,
        output db_level, press_tick, rel_tick, edge_cap, irq
    );
endinterface

// File: rtl/key_debounce_capture.sv
// Multi-channel key/switch debouncer with press/release ticks, sticky press
// capture and an interrupt line. One key_debounce_lane per input channel.

// One channel: 2-FF synchronizer, debounce FSM with a saturating-window counter,
// registered level/tick outputs and the sticky press-capture bit.
module key_debounce_lane #(
    parameter int CNT_W      = 20,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    input  logic clr,
    output logic db_level,
    output logic press_tick,
    output logic rel_tick,
    output logic edge_cap
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    localparam logic [CNT_W-1:0] MAX = '1;

    logic             sync1, sync2, s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, rel_nxt;

    // Two-stage synchronizer; resets to the raw idle level so no false press appears.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Normalise polarity so 1 always means pressed/on.
    assign s = sync2 ^ ACTIVE_LOW;

    // Next-state logic: the MAX compare comes before the increment, so cnt never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            ZERO: begin
                if (s) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = '0;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_nxt = ZERO;
                end else if (cnt == MAX) begin
                    state_nxt = ONE;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ONE: begin
                if (!s) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = '0;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_nxt = ONE;
                end else if (cnt == MAX) begin
                    state_nxt = ZERO;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ZERO;
        endcase
    end

    // State, counter and registered outputs; a press on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ZERO;
            cnt        <= '0;
            db_level   <= 1'b0;
            press_tick <= 1'b0;
            rel_tick   <= 1'b0;
            edge_cap   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            db_level   <= (state_nxt == ONE) || (state_nxt == WAIT0);
            press_tick <= press_nxt;
            rel_tick   <= rel_nxt;
            edge_cap   <= press_nxt | (edge_cap & ~clr);
        end
    end
endmodule

module key_debounce_capture #(
    parameter int N          = 4,
    parameter int CNT_W      = 20,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic                  clk,
    input logic                  reset_n,
    key_debounce_capture_if.slave bus
);
    logic [N-1:0] db_level, press_tick, rel_tick, edge_cap, clr;

    assign clr = bus.clr_en ? bus.clr_mask : '0;

    // Channels are fully independent; one lane instance each.
    for (genvar i = 0; i < N; i++) begin : g_ch
        key_debounce_lane #(
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .din        (bus.din[i]),
            .clr        (clr[i]),
            .db_level   (db_level[i]),
            .press_tick (press_tick[i]),
            .rel_tick   (rel_tick[i]),
            .edge_cap   (edge_cap[i])
        );
    end

    assign bus.db_level   = db_level;
    assign bus.press_tick = press_tick;
    assign bus.rel_tick   = rel_tick;
    assign bus.edge_cap   = edge_cap;
    assign bus.irq        = |(edge_cap & bus.irq_mask);
endmodule

// File: tb/tb_key_debounce_capture.sv
// Bench for key_debounce_capture (N=4, CNT_W=4, ACTIVE_LOW=1): directed test-plan
// scenarios followed by random pin activity, all checked every cycle against a
// run-length reference model through a scoreboard queue.
module tb_key_debounce_capture;
    localparam int       N     = 4;
    localparam int       CNT_W = 4;
    localparam bit       AL    = 1'b1;
    localparam int       WIN   = (1 << CNT_W) + 1;  // consecutive opposite samples to flip
    localparam int       LAT   = 3 + (1 << CNT_W);  // edges from pin change to tick
    localparam logic [N-1:0] INACT = {N{AL}};

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] pt;
        logic [N-1:0] rt;
        logic [N-1:0] cap;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    key_debounce_capture_if #(.N(N)) bus ();

    key_debounce_capture #(.N(N), .CNT_W(CNT_W), .ACTIVE_LOW(AL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a channel's level flips once its synchronised input has
    // disagreed with it for WIN consecutive edges; pins reach the decision 2 edges late.
    logic [N-1:0] m_d1, m_d2, m_lvl, m_pt, m_rt, m_cap;
    int           m_run[N];

    always @(posedge clk) begin
        if (!reset_n) begin
            m_d1 = INACT; m_d2 = INACT;
            m_lvl = '0; m_pt = '0; m_rt = '0; m_cap = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            m_pt = '0; m_rt = '0;
            for (int i = 0; i < N; i++) begin
                if ((m_d2[i] ^ AL) != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == WIN) begin
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) m_pt[i] = 1'b1;
                        else          m_rt[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_cap = (m_cap & ~(bus.clr_en ? bus.clr_mask : '0)) | m_pt;
            m_d2 = m_d1;
            m_d1 = bus.din;
        end
        sb_q.push_back('{lvl: m_lvl, pt: m_pt, rt: m_rt, cap: m_cap});
    end

    // Monitor: the DUT presents a result every cycle; compare it mid-cycle.
    always @(negedge clk) begin
        exp_t e, a;
        logic ei;
        if (sb_q.size() != 0) begin
            e  = sb_q.pop_front();
            a  = '{lvl: bus.db_level, pt: bus.press_tick, rt: bus.rel_tick, cap: bus.edge_cap};
            ei = |(e.cap & bus.irq_mask);
            checks++;
            if (a !== e || bus.irq !== ei) begin
                failures++;
                $display("FAIL scoreboard t=%0t act lvl=%b pt=%b rt=%b cap=%b irq=%b exp lvl=%b pt=%b rt=%b cap=%b irq=%b",
                         $time, a.lvl, a.pt, a.rt, a.cap, bus.irq, e.lvl, e.pt, e.rt, e.cap, ei);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Counts edges from the stimulus to the tick (bounded), then checks it lasts one cycle.
    task automatic wait_tick(input int ch, input bit rel, input string name);
        int   found;
        logic t;
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            t = rel ? bus.rel_tick[ch] : bus.press_tick[ch];
            if (t === 1'b1) begin
                found = k;
                break;
            end
        end
        checks++;
        if (found != LAT) begin
            failures++;
            $display("FAIL %s_latency edge=%0d expected=%0d", name, found, LAT);
        end
        @(posedge clk);
        @(negedge clk);
        t = rel ? bus.rel_tick[ch] : bus.press_tick[ch];
        check1({name, "_width"}, t, 1'b0);
        check1({name, "_level"}, bus.db_level[ch], ~rel);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.din      = 4'b1111;
        bus.clr_en   = 1'b0;
        bus.clr_mask = '0;
        bus.irq_mask = 4'b0001;
        cyc(3);
        @(negedge clk);
        checks++;
        if ({bus.db_level, bus.press_tick, bus.rel_tick, bus.edge_cap, bus.irq} !== '0) begin
            failures++;
            $display("FAIL reset_outputs lvl=%b pt=%b rt=%b cap=%b irq=%b expected all 0",
                     bus.db_level, bus.press_tick, bus.rel_tick, bus.edge_cap, bus.irq);
        end
        reset_n = 1'b1;
        cyc(5);

        // Clean press on channel 0
        bus.din[0] = 1'b0;
        wait_tick(0, 1'b0, "clean_press");
        check1("press_cap0", bus.edge_cap[0], 1'b1);
        check1("press_irq", bus.irq, 1'b1);

        // Bounce on channel 1: three 10-cycle lows are too short to register
        for (int r = 0; r < 3; r++) begin
            bus.din[1] = 1'b0; cyc(10);
            bus.din[1] = 1'b1; cyc(10);
        end
        check1("bounce_level", bus.db_level[1], 1'b0);
        bus.din[1] = 1'b0;
        wait_tick(1, 1'b0, "bounce_press");

        // Release channel 0; capture stays set
        bus.din[0] = 1'b1;
        wait_tick(0, 1'b1, "release");
        check1("release_cap0", bus.edge_cap[0], 1'b1);

        // Clear of channels 0 and 2 on the same edge channel 2's press is generated
        bus.din[2] = 1'b0;
        cyc(LAT - 1);
        bus.clr_en   = 1'b1;
        bus.clr_mask = 4'b0101;
        cyc(1);
        bus.clr_en   = 1'b0;
        bus.clr_mask = '0;
        @(negedge clk);
        check1("setclr_tick2", bus.press_tick[2], 1'b1);
        check1("setclr_cap2", bus.edge_cap[2], 1'b1);
        check1("setclr_cap0", bus.edge_cap[0], 1'b0);

        // Reset in the middle of channel 3's debounce
        bus.din[3] = 1'b0;
        cyc(9);
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        wait_tick(3, 1'b0, "reset_mid_press");

        // Random pin activity, clears, mask changes and rare resets
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(39) == 0) bus.din[i] = ~bus.din[i];
            bus.clr_en   = ($urandom_range(7) == 0);
            bus.clr_mask = 4'($urandom);
            if ($urandom_range(49) == 0) bus.irq_mask = 4'($urandom);
            reset_n = ($urandom_range(599) != 0);
            cyc(1);
        end
        reset_n    = 1'b1;
        bus.clr_en = 1'b0;
        cyc(2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
